// File: rtl/cache_pkg.sv
// Shared field widths, address slice positions and FSM state encoding for the
// 2-way, 8-set cache miss/replacement controller.
package cache_pkg;

    localparam int TAG_W   = 24;
    localparam int IDX_W   = 3;
    localparam int OFF_W   = 3;

    // Byte address layout: tag | index | word | byte
    localparam int WORD_LSB = 2;
    localparam int IDX_LSB  = WORD_LSB + OFF_W;
    localparam int TAG_LSB  = IDX_LSB + IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        COMMIT = 2'd2,
        WTHRU  = 2'd3
    } state_t;

endpackage

// File: rtl/cache_lru.sv
// One LRU bit per set; the bit names the way to evict next in that set.
module cache_lru
    import cache_pkg::*;
#(
    parameter int SETS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_val,
    output logic             victim
);

    logic [SETS-1:0] lru_r;

    // LRU bit store, all sets point at way 0 after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            lru_r <= '0;
        end else if (upd_en) begin
            lru_r[upd_idx] <= upd_val;
        end else begin
            lru_r <= lru_r;
        end
    end

    assign victim = lru_r[rd_idx];

endmodule

// File: rtl/cache_controller.sv
// Miss-handling and LRU replacement controller: burst refill on load miss,
// write-through/no-allocate stores. Define CACHE_STATS_EN for hit/miss counters.
module cache_controller
    import cache_pkg::*;
#(
    parameter int WORDS = 8,
    parameter int SETS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic [IDX_W-1:0]  tc_line_read,
    output logic [TAG_W-1:0]  tc_tag_read,
    input  logic              tc_hit,
    input  logic              tc_channel,
    output logic              tc_write,
    output logic              tc_pos,
    output logic [IDX_W-1:0]  tc_line_write,
    output logic [TAG_W-1:0]  tc_tag_write,
    output logic              data_we,
    output logic              data_way,
    output logic [IDX_W-1:0]  data_line,
    output logic [OFF_W-1:0]  data_word,
    output logic [31:0]       data_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
`ifdef CACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    state_t             state_r;
    logic [TAG_W-1:0]   tag_r;
    logic [IDX_W-1:0]   idx_r;
    logic               victim_r;
    logic [OFF_W-1:0]   cnt_r;

    logic [TAG_W-1:0]   addr_tag_s;
    logic [IDX_W-1:0]   addr_idx_s;
    logic [OFF_W-1:0]   addr_word_s;
    logic               lru_victim_s;
    logic               lru_upd_s;
    logic [IDX_W-1:0]   lru_upd_idx_s;
    logic               lru_upd_val_s;
    logic               load_hit_s;
    logic               load_miss_s;

    assign addr_tag_s   = cpu_addr[TAG_LSB +: TAG_W];
    assign addr_idx_s   = cpu_addr[IDX_LSB +: IDX_W];
    assign addr_word_s  = cpu_addr[WORD_LSB +: OFF_W];
    assign tc_line_read = addr_idx_s;
    assign tc_tag_read  = addr_tag_s;

    assign load_hit_s  = (state_r == IDLE) & cpu_req & ~cpu_we &  tc_hit;
    assign load_miss_s = (state_r == IDLE) & cpu_req & ~cpu_we & ~tc_hit;

    cache_lru #(.SETS(SETS)) u_lru (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (addr_idx_s),
        .upd_en  (lru_upd_s),
        .upd_idx (lru_upd_idx_s),
        .upd_val (lru_upd_val_s),
        .victim  (lru_victim_s)
    );

    // Controller FSM plus the refill context latched at miss time
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            tag_r    <= '0;
            idx_r    <= '0;
            victim_r <= 1'b0;
            cnt_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_req && cpu_we) begin
                        state_r <= WTHRU;
                    end else if (load_miss_s) begin
                        state_r  <= REFILL;
                        tag_r    <= addr_tag_s;
                        idx_r    <= addr_idx_s;
                        victim_r <= lru_victim_s;
                        cnt_r    <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        cnt_r <= cnt_r + OFF_W'(1);
                        if (cnt_r == LAST_WORD) begin
                            state_r <= COMMIT;
                        end else begin
                            state_r <= REFILL;
                        end
                    end else begin
                        state_r <= REFILL;
                    end
                end
                COMMIT: begin
                    state_r <= IDLE;
                end
                WTHRU: begin
                    if (mem_ack) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WTHRU;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Per-state output decode; everything is held low while rst is asserted
    always_comb begin
        cpu_ready     = 1'b0;
        tc_write      = 1'b0;
        tc_pos        = 1'b0;
        tc_line_write = '0;
        tc_tag_write  = '0;
        data_we       = 1'b0;
        data_way      = 1'b0;
        data_line     = '0;
        data_word     = '0;
        data_wdata    = 32'h0000_0000;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = 32'h0000_0000;
        mem_wdata     = 32'h0000_0000;
        lru_upd_s     = 1'b0;
        lru_upd_idx_s = '0;
        lru_upd_val_s = 1'b0;
        if (!rst) begin
            case (state_r)
                IDLE: begin
                    if (cpu_req && tc_hit) begin
                        lru_upd_s     = 1'b1;
                        lru_upd_idx_s = addr_idx_s;
                        lru_upd_val_s = ~tc_channel;
                        if (cpu_we) begin
                            data_we    = 1'b1;
                            data_way   = tc_channel;
                            data_line  = addr_idx_s;
                            data_word  = addr_word_s;
                            data_wdata = cpu_wdata;
                        end else begin
                            cpu_ready = 1'b1;
                        end
                    end else begin
                        cpu_ready = 1'b0;
                    end
                end
                REFILL: begin
                    mem_req  = 1'b1;
                    mem_addr = {tag_r, idx_r, cnt_r, 2'b00};
                    if (mem_ack) begin
                        data_we    = 1'b1;
                        data_way   = victim_r;
                        data_line  = idx_r;
                        data_word  = cnt_r;
                        data_wdata = mem_rdata;
                    end else begin
                        data_we = 1'b0;
                    end
                end
                COMMIT: begin
                    tc_write      = 1'b1;
                    tc_pos        = victim_r;
                    tc_line_write = idx_r;
                    tc_tag_write  = tag_r;
                    lru_upd_s     = 1'b1;
                    lru_upd_idx_s = idx_r;
                    lru_upd_val_s = ~victim_r;
                end
                WTHRU: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = cpu_addr & ~32'd3;
                    mem_wdata = cpu_wdata;
                    cpu_ready = mem_ack;
                end
                default: begin
                    cpu_ready = 1'b0;
                end
            endcase
        end else begin
            cpu_ready = 1'b0;
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating load-hit and refill-start counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= 32'h0000_0000;
            miss_count <= 32'h0000_0000;
        end else begin
            if (load_hit_s && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                hit_count <= hit_count;
            end
            if (load_miss_s && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end else begin
                miss_count <= miss_count;
            end
        end
    end
`endif

endmodule
